// File: rtl/vit_class_head_engine.sv
// Classification head: computes logits[c] = sum_e cls[e]*W[e][c] + b[c] on one shared
// signed fixed-point MAC, saturates each logit to DATA_WIDTH and tracks the argmax class.
module vit_class_head_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int E           = 128,
  parameter int NUM_CLASSES = 1000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  done,
  output logic                                  busy,
  input  logic [DATA_WIDTH*E-1:0]               cls_in,
  input  logic [DATA_WIDTH*E*NUM_CLASSES-1:0]   W_clf_in,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0]     b_clf_in,
  output logic [DATA_WIDTH*NUM_CLASSES-1:0]     logits_out,
  output logic                                  out_valid,
  output logic [$clog2(NUM_CLASSES)-1:0]        pred_class
);

  localparam int CW   = $clog2(NUM_CLASSES);
  localparam int EW   = (E > 1) ? $clog2(E) : 1;
  localparam int ACCW = 2*DATA_WIDTH + $clog2(E);

  localparam logic signed [ACCW:0] SAT_HI = {{(ACCW+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_LO = {{(ACCW+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t                         state;
  logic [DATA_WIDTH*E-1:0]        cls_reg;
  logic [EW-1:0]                  e_cnt;
  logic [CW-1:0]                  c_cnt;
  logic signed [ACCW-1:0]         acc;
  logic signed [DATA_WIDTH-1:0]   max_val;
  logic [CW-1:0]                  max_idx;

  logic signed [DATA_WIDTH-1:0]   cls_elem;
  logic signed [DATA_WIDTH-1:0]   w_elem;
  logic signed [DATA_WIDTH-1:0]   b_elem;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACCW-1:0]         acc_next;
  logic signed [ACCW-1:0]         shifted;
  logic signed [ACCW:0]           sum;
  logic signed [DATA_WIDTH-1:0]   sat_val;
  logic                           better;
  logic                           last_e;
  logic                           last_c;

  assign last_e = (e_cnt == EW'(E-1));
  assign last_c = (c_cnt == CW'(NUM_CLASSES-1));

  // Datapath: the product is sign-extended into the wide accumulator, and the
  // arithmetic shift rounds toward negative infinity before the bias add.
  always_comb begin
    cls_elem = cls_reg[DATA_WIDTH*int'(e_cnt) +: DATA_WIDTH];
    w_elem   = W_clf_in[DATA_WIDTH*(int'(e_cnt)*NUM_CLASSES + int'(c_cnt)) +: DATA_WIDTH];
    b_elem   = b_clf_in[DATA_WIDTH*int'(c_cnt) +: DATA_WIDTH];
    product  = cls_elem * w_elem;
    acc_next = acc + {{(ACCW-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
    shifted  = acc >>> FRAC_BITS;
    sum      = {shifted[ACCW-1], shifted}
             + {{(ACCW+1-DATA_WIDTH){b_elem[DATA_WIDTH-1]}}, b_elem};
    sat_val  = sum[DATA_WIDTH-1:0];
    if (sum > SAT_HI)
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sum < SAT_LO)
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    better = (c_cnt == '0) || (sat_val > max_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      logits_out <= '0;
      pred_class <= '0;
      cls_reg    <= '0;
      e_cnt      <= '0;
      c_cnt      <= '0;
      acc        <= '0;
      max_val    <= '0;
      max_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cls_reg   <= cls_in;
            e_cnt     <= '0;
            c_cnt     <= '0;
            acc       <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (last_e)
            state <= WRITE;
          else
            e_cnt <= e_cnt + 1'b1;
        end
        WRITE: begin
          logits_out[DATA_WIDTH*int'(c_cnt) +: DATA_WIDTH] <= sat_val;
          if (better) begin
            max_val <= sat_val;
            max_idx <= c_cnt;
          end
          acc   <= '0;
          e_cnt <= '0;
          // Entering DONE: done pulses and pred_class is final during that cycle.
          if (last_c) begin
            pred_class <= better ? c_cnt : max_idx;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            c_cnt <= c_cnt + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vit_class_head_engine.sv
// Directed bench for vit_class_head_engine at E=4, NUM_CLASSES=3, Q7.8; each scenario
// task drives its own vectors and compares against hand-computed logits and cycle counts.
module tb_vit_class_head_engine;

  localparam int DW  = 16;
  localparam int EE  = 4;
  localparam int NC  = 3;
  localparam int LAT = 1 + NC*(EE+1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 done;
  logic                 busy;
  logic [DW*EE-1:0]     cls_in;
  logic [DW*EE*NC-1:0]  W_clf_in;
  logic [DW*NC-1:0]     b_clf_in;
  logic [DW*NC-1:0]     logits_out;
  logic                 out_valid;
  logic [1:0]           pred_class;

  logic [DW-1:0] cls_a [EE];
  logic [DW-1:0] w_a   [EE][NC];
  logic [DW-1:0] b_a   [NC];
  logic [DW-1:0] exp_l [NC];

  int checks   = 0;
  int failures = 0;

  vit_class_head_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .E(EE), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .cls_in(cls_in), .W_clf_in(W_clf_in), .b_clf_in(b_clf_in),
    .logits_out(logits_out), .out_valid(out_valid), .pred_class(pred_class)
  );

  always #5 clk = ~clk;

  task automatic pack_inputs();
    for (int e = 0; e < EE; e++) begin
      cls_in[DW*e +: DW] = cls_a[e];
      for (int c = 0; c < NC; c++)
        W_clf_in[DW*(e*NC+c) +: DW] = w_a[e][c];
    end
    for (int c = 0; c < NC; c++)
      b_clf_in[DW*c +: DW] = b_a[c];
  endtask

  task automatic load_basic();
    cls_a = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
    for (int e = 0; e < EE; e++) w_a[e] = '{16'h0000, 16'h0000, 16'h0000};
    w_a[0][0] = 16'h0100; w_a[1][0] = 16'h0100; w_a[0][1] = 16'hFF00;
    b_a   = '{16'h0080, 16'h0000, 16'h0010};
    exp_l = '{16'h0380, 16'hFF00, 16'h0010};
    pack_inputs();
  endtask

  task automatic load_sat();
    for (int e = 0; e < EE; e++) begin
      cls_a[e] = 16'h7FFF;
      w_a[e]   = '{16'h7FFF, 16'h8000, 16'h0000};
    end
    b_a   = '{16'h0000, 16'h0000, 16'h0000};
    exp_l = '{16'h7FFF, 16'h8000, 16'h0000};
    pack_inputs();
  endtask

  task automatic load_tie();
    cls_a = '{16'h0300, 16'hFE00, 16'h0040, 16'h7000};
    for (int e = 0; e < EE; e++) w_a[e] = '{16'h0000, 16'h0000, 16'h0000};
    b_a   = '{16'h0010, 16'h0020, 16'h0020};
    exp_l = '{16'h0010, 16'h0020, 16'h0020};
    pack_inputs();
  endtask

  // Pulses start in cycle 0 and observes cycles 1..ncyc at the falling edge.
  task automatic run_cycles(input int ncyc, input int extra_start, input bit change_cls,
                            output int first_done, output int n_done, output int busy_err,
                            output logic ov_after);
    first_done = -1; n_done = 0; busy_err = 0; ov_after = 1'bx;
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start = (n == extra_start);
      if (change_cls && n == 1) cls_in = {EE{16'h4000}};
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      if (busy !== (n <= LAT)) busy_err++;
      if (n == LAT+1) ov_after = out_valid;
    end
    start = 1'b0;
  endtask

  task automatic check_logits(input string tag);
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (logits_out[DW*c +: DW] !== exp_l[c]) begin
        failures++;
        $display("[TB] FAIL %s logit%0d got=%h want=%h", tag, c, logits_out[DW*c +: DW], exp_l[c]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    load_basic();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({done, busy, out_valid, pred_class} !== 5'b0 || logits_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state got done=%b busy=%b ov=%b pred=%0d logits=%h want all zero",
               done, busy, out_valid, pred_class, logits_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int fd, nd, be; logic ov;
    load_basic();
    run_cycles(LAT+2, -1, 1'b0, fd, nd, be, ov);
    checks++;
    if (fd !== LAT || nd !== 1) begin
      failures++;
      $display("[TB] FAIL basic_done first=%0d count=%0d want first=%0d count=1", fd, nd, LAT);
    end
    checks++;
    if (be !== 0) begin
      failures++;
      $display("[TB] FAIL basic_busy bad_cycles=%0d want 0", be);
    end
    checks++;
    if (ov !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_out_valid got=%b want 1", ov);
    end
    check_logits("basic");
    checks++;
    if (pred_class !== 2'd0) begin
      failures++;
      $display("[TB] FAIL basic_pred got=%0d want 0", pred_class);
    end
  endtask

  task automatic test_saturation();
    int fd, nd, be; logic ov;
    load_sat();
    run_cycles(LAT+2, -1, 1'b0, fd, nd, be, ov);
    checks++;
    if (fd !== LAT) begin
      failures++;
      $display("[TB] FAIL sat_done got=%0d want %0d", fd, LAT);
    end
    check_logits("sat");
    checks++;
    if (pred_class !== 2'd0) begin
      failures++;
      $display("[TB] FAIL sat_pred got=%0d want 0", pred_class);
    end
  endtask

  task automatic test_argmax_tie();
    int fd, nd, be; logic ov;
    load_tie();
    run_cycles(LAT+2, -1, 1'b0, fd, nd, be, ov);
    check_logits("tie");
    checks++;
    if (pred_class !== 2'd1) begin
      failures++;
      $display("[TB] FAIL tie_pred got=%0d want 1", pred_class);
    end
  endtask

  task automatic test_start_while_busy();
    int fd, nd, be; logic ov;
    load_basic();
    run_cycles(LAT+4, 5, 1'b1, fd, nd, be, ov);
    checks++;
    if (fd !== LAT || nd !== 1) begin
      failures++;
      $display("[TB] FAIL busy_start_done first=%0d count=%0d want first=%0d count=1", fd, nd, LAT);
    end
    checks++;
    if (be !== 0) begin
      failures++;
      $display("[TB] FAIL busy_start_busy bad_cycles=%0d want 0", be);
    end
    check_logits("busy_start");
  endtask

  task automatic test_reset_mid();
    int fd = -1, nd_early = 0;
    load_sat();
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      start = (n == 12);
      rst   = (n == 8);
      if (n == 9) begin
        checks++;
        if ({done, busy, out_valid, pred_class} !== 5'b0 || logits_out !== '0) begin
          failures++;
          $display("[TB] FAIL reset_mid_zero got done=%b busy=%b ov=%b pred=%0d logits=%h want all zero",
                   done, busy, out_valid, pred_class, logits_out);
        end
      end
      if (done === 1'b1) begin
        if (n <= 12) nd_early++;
        else if (fd < 0) fd = n;
      end
    end
    start = 1'b0;
    checks++;
    if (nd_early !== 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_done got=%0d pulses want 0", nd_early);
    end
    checks++;
    if (fd !== 12 + LAT) begin
      failures++;
      $display("[TB] FAIL reset_mid_done_cycle got=%0d want %0d", fd, 12 + LAT);
    end
    check_logits("reset_mid");
  endtask

  task automatic test_back_to_back();
    int fd, nd, be, fd2 = -1; logic ov;
    load_basic();
    run_cycles(LAT, -1, 1'b0, fd, nd, be, ov);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_ov_before got=%b want 1", out_valid);
    end
    load_tie();
    start = 1'b1;
    for (int n = 1; n <= LAT+3; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_ov_cleared got=%b want 0", out_valid);
        end
      end
      if (done === 1'b1 && fd2 < 0) fd2 = n;
    end
    checks++;
    if (fd2 !== LAT) begin
      failures++;
      $display("[TB] FAIL b2b_done got=%0d want %0d", fd2, LAT);
    end
    check_logits("b2b");
    checks++;
    if (pred_class !== 2'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_pred got pred=%0d ov=%b want pred=1 ov=1", pred_class, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_argmax_tie();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
